// File: rtl/tick_generator.sv
// Programmable clock-enable generator: one-cycle tick every div_q enabled cycles,
// a slow_tick on every SUB_DIV-th tick, with periodic and one-shot modes.
module tick_generator #(
    parameter int CNT_W       = 28,
    parameter int DIV_DEFAULT = 100000000,
    parameter int SUB_DIV     = 60,
    parameter int AUTO_START  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             oneshot_in,
    input  logic             stop,
    output logic             tick,
    output logic             slow_tick,
    output logic             busy,
    output logic             load_err,
    output logic [CNT_W-1:0] cnt
);

    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic             busy_q;
    logic             err_q;

    logic load_ok, load_bad, stop_eff, run_en, terminal, sub_wrap;

    // A rejected load (div_in = 0) does not mask a simultaneous stop.
    assign load_ok  = load && (div_in != '0);
    assign load_bad = load && (div_in == '0);
    assign stop_eff = stop && !load_ok;
    assign run_en   = (state_q == S_RUN) && en;
    assign terminal = run_en && (count_q == div_q - CNT_W'(1));
    assign sub_wrap = (sub_q == SUB_W'(SUB_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (AUTO_START != 0) ? S_RUN : S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_ok) begin
            state_d = S_RUN;
        end else if (stop_eff) begin
            state_d = S_IDLE;
        end else if (terminal && mode_q) begin
            state_d = S_DONE;
        end
    end

    // Load and stop take priority over the terminal count, which suppresses that tick.
    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        count_d = count_q;
        sub_d   = sub_q;
        tick_d  = 1'b0;
        slow_d  = 1'b0;
        if (load_ok) begin
            div_d   = div_in;
            mode_d  = oneshot_in;
            count_d = '0;
            sub_d   = '0;
        end else if (stop_eff) begin
            count_d = '0;
            sub_d   = '0;
        end else if (terminal) begin
            count_d = '0;
            tick_d  = 1'b1;
            slow_d  = sub_wrap;
            sub_d   = sub_wrap ? '0 : sub_q + SUB_W'(1);
        end else if (run_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= CNT_W'(DIV_DEFAULT);
            mode_q  <= 1'b0;
            count_q <= '0;
            sub_q   <= '0;
            tick_q  <= 1'b0;
            slow_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            sub_q   <= sub_d;
            tick_q  <= tick_d;
            slow_q  <= slow_d;
            busy_q  <= (state_d == S_RUN);
            err_q   <= load_bad;
        end
    end

    assign tick      = tick_q;
    assign slow_tick = slow_q;
    assign busy      = busy_q;
    assign load_err  = err_q;
    assign cnt       = count_q;

endmodule

// File: tb/tb_tick_generator.sv
// Randomised and directed bench for tick_generator with a queue-based scoreboard
// fed by a period/tick-count reference model.
module tb_tick_generator;

  localparam int CNT_W = 8;
  localparam int DIV_DEF = 5;
  localparam int SUB_DIV = 3;
  localparam int W = 4 + CNT_W;

  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic oneshot_in = 1'b0;
  logic stop = 1'b0;
  logic tick, slow_tick, busy, load_err;
  logic [CNT_W-1:0] cnt;

  tick_generator #(
    .CNT_W(CNT_W),
    .DIV_DEFAULT(DIV_DEF),
    .SUB_DIV(SUB_DIV),
    .AUTO_START(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .div_in(div_in),
    .oneshot_in(oneshot_in),
    .stop(stop),
    .tick(tick),
    .slow_tick(slow_tick),
    .busy(busy),
    .load_err(load_err),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int slow_seen = 0;

  // reference model: elapsed enabled cycles in the period and ticks since restart
  int m_div, m_phase, m_ticks, m_state;
  logic m_mode;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div = DIV_DEF;
    m_mode = 1'b0;
    m_phase = 0;
    m_ticks = 0;
    m_state = M_RUN;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [CNT_W-1:0] d,
                            input logic os, input logic s);
    logic t, sl, er, b;
    t = 1'b0;
    sl = 1'b0;
    er = l && (d == 0);
    if (l && d != 0) begin
      m_div = int'(d);
      m_mode = os;
      m_phase = 0;
      m_ticks = 0;
      m_state = M_RUN;
    end else if (s) begin
      m_state = M_IDLE;
      m_phase = 0;
      m_ticks = 0;
    end else if (m_state == M_RUN && e) begin
      m_phase++;
      if (m_phase == m_div) begin
        m_phase = 0;
        t = 1'b1;
        m_ticks++;
        sl = (m_ticks % SUB_DIV) == 0;
        if (m_mode) m_state = M_DONE;
      end
    end
    b = (m_state == M_RUN);
    exp_q.push_back({t, sl, b, er, CNT_W'(m_phase)});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic e, input logic l, input logic [CNT_W-1:0] d,
                       input logic os, input logic s);
    en = e;
    load = l;
    div_in = d;
    oneshot_in = os;
    stop = s;
    model_step(e, l, d, os, s);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {28'd0, tick, slow_tick, busy, load_err}, 32'd0);
    check({name, "_cnt"}, {24'd0, cnt}, 32'd0);
  endtask

  initial begin
    int t0, s0;

    fork
      forever begin
        logic [W-1:0] exp_v;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("cycle_out", {20'd0, tick, slow_tick, busy, load_err, cnt}, {20'd0, exp_v});
          if (tick) tick_seen++;
          if (slow_tick) slow_seen++;
        end
      end
    join_none

    // reset held over two edges, released mid-cycle
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_out");
    #2;
    rst = 1'b0;
    model_reset();

    // periodic: ticks on 5,10,...,30 and slow ticks on 15 and 30
    t0 = tick_seen;
    s0 = slow_seen;
    run(30);
    check("periodic_ticks", tick_seen - t0, 6);
    check("periodic_slow", slow_seen - s0, 2);

    // pause at count 2
    run(2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("pause_cnt", {24'd0, cnt}, 32'd2);
    run(3);
    check("pause_tick", {31'd0, tick}, 32'd1);

    // one-shot with divisor 3
    t0 = tick_seen;
    cycle(1'b1, 1'b1, 8'd3, 1'b1, 1'b0);
    run(23);
    check("oneshot_ticks", tick_seen - t0, 1);
    check("oneshot_busy", {31'd0, busy}, 32'd0);

    // rejected load then divisor 1
    cycle(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
    run(2);
    cycle(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check("load_err_pulse", {31'd0, load_err}, 32'd1);
    run(6);
    cycle(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    t0 = tick_seen;
    run(5);
    check("div1_ticks", tick_seen - t0, 5);

    // load and stop together
    cycle(1'b1, 1'b1, 8'd4, 1'b0, 1'b1);
    t0 = tick_seen;
    run(12);
    check("load_stop_ticks", tick_seen - t0, 3);

    // stop exactly at a terminal count
    for (int i = 0; i < 8 && !(m_state == M_RUN && m_phase == m_div - 1); i++) run(1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("stop_term", {30'd0, tick, busy}, 32'd0);
    run(4);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic e, l, os, s;
      logic [CNT_W-1:0] d;
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 99) < 5);
      d = CNT_W'($urandom_range(0, 7));
      os = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 99) < 3);
      cycle(e, l, d, os, s);
    end

    // asynchronous reset mid-period at count 3
    cycle(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
    run(3);
    check("pre_reset_cnt", {24'd0, cnt}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_out");
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    t0 = tick_seen;
    run(4);
    check("post_reset_early", tick_seen - t0, 0);
    run(1);
    check("post_reset_first", tick_seen - t0, 1);
    run(5);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 Parameters: name, default, meaning.
- CNT_W, 28, width of divisor and counter.
- DIV_DEFAULT, 100000000, divisor loaded at reset; must be >= 1 and < 2^CNT_W.
- SUB_DIV, 60, number of ticks per slow_tick; must be >= 1.
- AUTO_START, 1, 1 = reset into RUN, 0 = reset into IDLE.
REQ-002 Ports: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  level; 1 = counting, 0 = pause (count held).
- load  in  1  one-cycle pulse; apply div_in and oneshot_in, restart.
- div_in  in  CNT_W  new divisor, sampled when load=1.
- oneshot_in  in  1  mode, sampled when load=1; 1 = one-shot, 0 = periodic.
- stop  in  1  one-cycle pulse; return to IDLE.
- tick  out  1  registered one-cycle clock-enable pulse.
- slow_tick  out  1  registered pulse, coincident with every SUB_DIV-th tick.
- busy  out  1  1 while state = RUN.
- load_err  out  1  one-cycle pulse, load rejected.
- cnt  out  CNT_W  current counter value.

Function
REQ-003 The block SHALL be a clock-enable generator only; tick SHALL never drive any clock pin.
REQ-004 The block SHALL implement the states IDLE, RUN and DONE.
REQ-005 Internal registers SHALL be div_q (CNT_W), mode_q, count (CNT_W) and sub_cnt (width clog2(SUB_DIV), minimum 1).
REQ-006 The RUN cycle rule SHALL be as follows when en=1:
- count = div_q-1: count<=0 and tick<=1 next cycle.
- otherwise: count<=count+1 and tick<=0.
REQ-007 In RUN the tick period SHALL be exactly div_q enabled cycles; div_q=1 SHALL give tick=1 every enabled cycle.
REQ-008 When en=0 in RUN, count, sub_cnt and state SHALL hold, and tick and slow_tick SHALL be 0 on the next cycle.
REQ-009 On each terminal count, sub_cnt SHALL increment.
- If sub_cnt = SUB_DIV-1: sub_cnt<=0 and slow_tick<=1, in the same cycle as tick.
- SUB_DIV=1: slow_tick SHALL equal tick.
REQ-010 In one-shot mode (mode_q=1), the terminal count SHALL produce exactly one tick and move the state to DONE.
REQ-011 In IDLE and DONE, count SHALL hold at 0 and tick, slow_tick and busy SHALL be 0.
REQ-012 A load with div_in != 0, in any state, SHALL in one cycle set:
- div_q<=div_in, mode_q<=oneshot_in;
- count<=0, sub_cnt<=0, tick<=0, slow_tick<=0;
- state<=RUN.
Counting SHALL resume on the following cycle.
REQ-013 A load with div_in = 0 SHALL leave all state unchanged and SHALL pulse load_err=1 for one cycle.
REQ-014 A stop SHALL set state<=IDLE, count<=0, sub_cnt<=0, tick<=0 and slow_tick<=0.
REQ-015 Simultaneous load and stop: load SHALL win, and load_err SHALL still apply if div_in = 0, in which case stop SHALL take effect.
REQ-016 load or stop in the same cycle as a terminal count SHALL suppress that tick.
REQ-017 cnt SHALL equal count.
REQ-018 busy SHALL be a registered decode of state = RUN.
REQ-019 count SHALL never exceed div_q-1, and no arithmetic wrap SHALL occur.

Reset
REQ-020 rst=1 SHALL asynchronously set the following:
- count=0, sub_cnt=0;
- tick=0, slow_tick=0, load_err=0;
- div_q=DIV_DEFAULT, mode_q=0;
- state=RUN if AUTO_START=1, else IDLE.
REQ-021 Reset asserted mid-period SHALL discard the partial count, with no tick emitted.
REQ-022 After rst deasserts with en=1, the first tick SHALL occur DIV_DEFAULT cycles later.

Verification
REQ-023 Bench parameters SHALL be DIV_DEFAULT=5, SUB_DIV=3, AUTO_START=1, CNT_W=8.
REQ-024 Periodic: release reset, en=1 for 30 cycles -> tick on cycles 5,10,15,20,25,30; slow_tick on cycles 15 and 30 only.
REQ-025 Pause: en=0 for 4 cycles at count=2 -> cnt holds 2; next tick arrives 3 enabled cycles after en returns to 1.
REQ-026 One-shot: load, div_in=3, oneshot_in=1 -> single tick 3 cycles later, then busy=0 (DONE); no further ticks for 20 cycles.
REQ-027 Load edge cases:
- load with div_in=0 -> load_err pulses once, with cnt and period unchanged.
- load with div_in=1 -> tick every cycle.
REQ-028 Simultaneous events:
- load and stop together with div_in=4 -> RUN with period 4.
- stop at a terminal count -> no tick, busy=0.
REQ-029 Asynchronous reset asserted mid-cycle at count=3 -> all outputs 0 immediately; first tick 5 cycles after release.
